// File: rtl/byte_visual_pkg.sv
// rtl/byte_visual_pkg.sv - shared types and constants for the byte-visual LED board input stage
package byte_visual_pkg;

  // Per-button press/repeat state.
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2
  } btn_state_t;

  // 10 ms sample period at a 12 MHz system clock.
  localparam int TICK_DIV_10MS = 120000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button inputs and conditioned pulse/level outputs
interface button_conditioner_if;

  logic BUT1;
  logic BUT2;
  logic UP_PULSE;
  logic DOWN_PULSE;
  logic BUT1_LEVEL;
  logic BUT2_LEVEL;

  // Board side: drives the raw buttons, consumes the conditioned signals.
  modport master (
    output BUT1,
    output BUT2,
    input  UP_PULSE,
    input  DOWN_PULSE,
    input  BUT1_LEVEL,
    input  BUT2_LEVEL
  );

  // Conditioner side.
  modport slave (
    input  BUT1,
    input  BUT2,
    output UP_PULSE,
    output DOWN_PULSE,
    output BUT1_LEVEL,
    output BUT2_LEVEL
  );

endinterface

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, debounce, press/auto-repeat FSM
module button_channel
  import byte_visual_pkg::*;
#(
  parameter int STABLE_TICKS       = 3,
  parameter int REPEAT_DELAY_TICKS = 50,
  parameter int REPEAT_RATE_TICKS  = 10,
  parameter int REPEAT_EN          = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  input  logic tick,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(max_int(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS) + 1);
  localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(REPEAT_DELAY_TICKS);
  localparam logic [CNT_W-1:0] RATE_CNT  = CNT_W'(REPEAT_RATE_TICKS);

  logic [1:0]              sync_q;
  logic                    synced;
  logic [STABLE_TICKS-1:0] samples_q;
  logic [STABLE_TICKS-1:0] samples_next;
  logic                    level_next;

  btn_state_t              state_q;
  btn_state_t              state_next;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_next;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    pulse_next;

  assign synced = sync_q[1];

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // On each tick shift in a sample; a full window of agreeing samples sets the level.
  always_comb begin
    samples_next = samples_q;
    level_next   = level;
    if (tick) begin
      samples_next = {samples_q[STABLE_TICKS-2:0], synced};
      if (&samples_next) begin
        level_next = 1'b1;
      end else if (~|samples_next) begin
        level_next = 1'b0;
      end
    end
  end

  // Sample window and debounced level registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      samples_q <= '0;
      level     <= 1'b0;
    end else begin
      samples_q <= samples_next;
      level     <= level_next;
    end
  end

  // Press/repeat decisions. A release is detected from level_next so that a level
  // falling on the same tick as a due repeat suppresses that repeat.
  always_comb begin
    state_next = state_q;
    cnt_next   = cnt_q;
    pulse_next = 1'b0;
    cnt_inc    = cnt_q + CNT_W'(1);
    case (state_q)
      RELEASED: begin
        if (level) begin
          pulse_next = 1'b1;
          cnt_next   = '0;
          state_next = HELD;
        end
      end
      HELD: begin
        if (!level_next) begin
          state_next = RELEASED;
        end else if (tick && (cnt_q != DELAY_CNT)) begin
          // Without auto-repeat the counter parks at the delay value.
          if ((REPEAT_EN != 0) && (cnt_inc == DELAY_CNT)) begin
            pulse_next = 1'b1;
            cnt_next   = '0;
            state_next = REPEAT;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      REPEAT: begin
        if (!level_next) begin
          state_next = RELEASED;
        end else if (tick) begin
          if (cnt_inc == RATE_CNT) begin
            pulse_next = 1'b1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      default: begin
        state_next = RELEASED;
      end
    endcase
  end

  // FSM state, repeat counter and registered pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      pulse   <= pulse_next;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - shared sample-tick prescaler and two button channels
module button_conditioner
  import byte_visual_pkg::*;
#(
  parameter int TICK_DIV           = TICK_DIV_10MS,
  parameter int STABLE_TICKS       = 3,
  parameter int REPEAT_DELAY_TICKS = 50,
  parameter int REPEAT_RATE_TICKS  = 10,
  parameter int REPEAT_EN          = 1
) (
  input logic                 CLK,
  input logic                 RST_N,
  button_conditioner_if.slave bus
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  // Free-running prescaler; tick marks the last count of each period.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  button_channel #(
    .STABLE_TICKS      (STABLE_TICKS),
    .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
    .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS),
    .REPEAT_EN         (REPEAT_EN)
  ) u_up (
    .CLK  (CLK),
    .RST_N(RST_N),
    .raw  (bus.BUT1),
    .tick (tick),
    .level(bus.BUT1_LEVEL),
    .pulse(bus.UP_PULSE)
  );

  button_channel #(
    .STABLE_TICKS      (STABLE_TICKS),
    .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
    .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS),
    .REPEAT_EN         (REPEAT_EN)
  ) u_down (
    .CLK  (CLK),
    .RST_N(RST_N),
    .raw  (bus.BUT2),
    .tick (tick),
    .level(bus.BUT2_LEVEL),
    .pulse(bus.DOWN_PULSE)
  );

endmodule
